// File: rtl/sys_health_monitor.sv
// ADC threshold health monitor: Wishbone-programmed per-channel min/max windows,
// debounced per-channel health bits and a critical-fault pulse for power_manager.
module sys_health_chan #(
  parameter logic [3:0] FAULT_COUNT   = 4'd3,
  parameter logic [3:0] RECOVER_COUNT = 4'd3,
  parameter logic       H_RST         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic en_nxt_i,
  input  logic smp_i,
  input  logic in_rng_i,
  output logic h_o,
  output logic h_nxt_o
);
  logic       h_q, h_d;
  logic [3:0] c_q, c_d, c_inc, lim;

  assign c_inc = c_q + 4'd1;
  assign lim   = h_q ? FAULT_COUNT : RECOVER_COUNT;

  // Enable writes take priority over the sample-driven update.
  always_comb begin
    h_d = h_q;
    c_d = c_q;
    if (!en_nxt_i) begin
      h_d = 1'b1;
      c_d = 4'd0;
    end else if (!en_i) begin
      h_d = 1'b0;
      c_d = 4'd0;
    end else if (smp_i) begin
      if (in_rng_i == h_q) begin
        c_d = 4'd0;
      end else if (c_inc == lim) begin
        h_d = ~h_q;
        c_d = 4'd0;
      end else begin
        c_d = c_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= H_RST;
      c_q <= 4'd0;
    end else begin
      h_q <= h_d;
      c_q <= c_d;
    end
  end

  assign h_o     = h_q;
  assign h_nxt_o = h_d;
endmodule

module sys_health_monitor #(
  parameter logic [3:0]  FAULT_COUNT            = 4'd3,
  parameter logic [3:0]  RECOVER_COUNT          = 4'd3,
  parameter logic [31:0] CHANNEL_ENABLE_DEFAULT = 32'hFFFF_FFFF,
  parameter logic [31:0] UNSAFE_MASK_DEFAULT    = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        adc_valid,
  input  logic [4:0]  adc_channel,
  input  logic [11:0] adc_data,
  output logic [31:0] sys_health,
  output logic        unsafe_sys_health
);
  logic             ack_q, acc, wr;
  logic [15:0]      dat_q, rd_d;
  logic [31:0][11:0] min_q, max_q;
  logic [31:0]      mask_q, en_q, en_d, h, h_nxt, fall_q;
  logic             unsafe_q;
  logic             s_vld_q, in_rng;
  logic [4:0]       s_ch_q;
  logic [11:0]      s_dat_q, s_min_q, s_max_q;

  // ~ack_q keeps a held strobe from being acked twice for one access.
  assign acc = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = acc & wb_we_i;

  always_comb begin
    en_d = en_q;
    if (wr && wb_adr_i == 16'd68) en_d[15:0]  = wb_dat_i;
    if (wr && wb_adr_i == 16'd69) en_d[31:16] = wb_dat_i;
  end

  always_comb begin
    rd_d = 16'h0000;
    if (wb_adr_i < 16'd32)      rd_d = {4'h0, min_q[wb_adr_i[4:0]]};
    else if (wb_adr_i < 16'd64) rd_d = {4'h0, max_q[wb_adr_i[4:0]]};
    else begin
      case (wb_adr_i)
        16'd64:  rd_d = h[15:0];
        16'd65:  rd_d = h[31:16];
        16'd66:  rd_d = mask_q[15:0];
        16'd67:  rd_d = mask_q[31:16];
        16'd68:  rd_d = en_q[15:0];
        16'd69:  rd_d = en_q[31:16];
        default: rd_d = 16'h0000;
      endcase
    end
  end

  // Thresholds are captured in the same edge as any write, so the compare sees pre-write values.
  assign in_rng = (s_dat_q >= s_min_q) && (s_dat_q <= s_max_q);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 16'h0000;
      min_q    <= '0;
      max_q    <= '1;
      mask_q   <= UNSAFE_MASK_DEFAULT;
      en_q     <= CHANNEL_ENABLE_DEFAULT;
      s_vld_q  <= 1'b0;
      s_ch_q   <= 5'd0;
      s_dat_q  <= 12'h000;
      s_min_q  <= 12'h000;
      s_max_q  <= 12'h000;
      fall_q   <= 32'h0;
      unsafe_q <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= acc ? rd_d : 16'h0000;
      en_q  <= en_d;
      if (wr) begin
        if (wb_adr_i < 16'd32)      min_q[wb_adr_i[4:0]] <= wb_dat_i[11:0];
        else if (wb_adr_i < 16'd64) max_q[wb_adr_i[4:0]] <= wb_dat_i[11:0];
        else if (wb_adr_i == 16'd66) mask_q[15:0]  <= wb_dat_i;
        else if (wb_adr_i == 16'd67) mask_q[31:16] <= wb_dat_i;
      end
      s_vld_q  <= adc_valid;
      s_ch_q   <= adc_channel;
      s_dat_q  <= adc_data;
      s_min_q  <= min_q[adc_channel];
      s_max_q  <= max_q[adc_channel];
      fall_q   <= h & ~h_nxt & mask_q;
      unsafe_q <= |fall_q;
    end
  end

  for (genvar n = 0; n < 32; n++) begin : g_chan
    sys_health_chan #(
      .FAULT_COUNT  (FAULT_COUNT),
      .RECOVER_COUNT(RECOVER_COUNT),
      .H_RST        (~CHANNEL_ENABLE_DEFAULT[n])
    ) u_chan (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .en_i    (en_q[n]),
      .en_nxt_i(en_d[n]),
      .smp_i   (s_vld_q && (s_ch_q == 5'(n))),
      .in_rng_i(in_rng),
      .h_o     (h[n]),
      .h_nxt_o (h_nxt[n])
    );
  end

  assign sys_health        = h;
  assign unsafe_sys_health = unsafe_q;
  assign wb_ack_o          = ack_q;
  assign wb_dat_o          = dat_q;
endmodule

// File: tb/tb_sys_health_monitor.sv
// Directed bench for sys_health_monitor: debounce timing, critical pulse, enable
// handling, inverted window and a table of register-map accesses.
module tb_sys_health_monitor;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = 16'h0, wdat = 16'h0, rdat;
  logic        ack;
  logic        adc_valid = 1'b0;
  logic [4:0]  adc_ch = 5'd0;
  logic [11:0] adc_dat = 12'h0;
  logic [31:0] health;
  logic        unsafe;
  int tests = 0, fails = 0, ack_cnt = 0, unsafe_cnt = 0, accesses = 0;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[16];

  sys_health_monitor dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack),
    .adc_valid(adc_valid), .adc_channel(adc_ch), .adc_data(adc_dat),
    .sys_health(health), .unsafe_sys_health(unsafe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ack) ack_cnt++;
    if (unsafe) unsafe_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_acc(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] r);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    tick();
    n = 1;
    while (!ack && n < 8) begin
      tick();
      n++;
    end
    chk("ack_seen", ack, 1'b1);
    r = rdat;
    accesses++;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk("ack_single", ack, 1'b0);
  endtask

  task automatic send(input logic [4:0] c, input logic [11:0] d);
    adc_valid = 1'b1; adc_ch = c; adc_dat = d;
    tick();
    adc_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    vecs[0]  = '{1'b1, 16'd32,  16'hFABC, 16'h0000};
    vecs[1]  = '{1'b0, 16'd32,  16'h0000, 16'h0ABC};
    vecs[2]  = '{1'b0, 16'd36,  16'h0000, 16'h0700};
    vecs[3]  = '{1'b0, 16'd37,  16'h0000, 16'h0100};
    vecs[4]  = '{1'b0, 16'd7,   16'h0000, 16'h0900};
    vecs[5]  = '{1'b0, 16'd39,  16'h0000, 16'h0100};
    vecs[6]  = '{1'b1, 16'd64,  16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 16'd64,  16'h0000, 16'hFF6F};
    vecs[8]  = '{1'b0, 16'd65,  16'h0000, 16'hFFFF};
    vecs[9]  = '{1'b0, 16'd66,  16'h0000, 16'h0010};
    vecs[10] = '{1'b0, 16'd67,  16'h0000, 16'h0000};
    vecs[11] = '{1'b0, 16'd68,  16'h0000, 16'hFFFF};
    vecs[12] = '{1'b1, 16'd100, 16'h1234, 16'h0000};
    vecs[13] = '{1'b0, 16'd100, 16'h0000, 16'h0000};
    vecs[14] = '{1'b0, 16'd69,  16'h0000, 16'hFFFF};
    vecs[15] = '{1'b0, 16'd0,   16'h0000, 16'h0000};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_health", health, 32'h0);
    chk("rst_unsafe", unsafe, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", rdat, 16'h0);

    // Recovery of every channel: bit rises two edges after its third sample.
    for (int c = 0; c < 32; c++) begin
      repeat (3) send(5'(c), 12'h800);
      chk("recover_early", health[c], 1'b0);
      tick();
      chk("recover_bit", health[c], 1'b1);
    end
    chk("all_healthy", health, 32'hFFFF_FFFF);
    chk("no_pulse_recover", unsafe_cnt, 0);

    // Masked ch4: interrupted run must not trip, then a clean run of three does.
    wb_acc(1'b1, 16'd36, 16'h0700, r);
    wb_acc(1'b1, 16'd66, 16'h0010, r);
    send(5'd4, 12'h800); tick();
    send(5'd4, 12'h800); tick();
    chk("ch4_two_bad", health[4], 1'b1);
    send(5'd4, 12'h600); tick();
    send(5'd4, 12'h800); tick();
    send(5'd4, 12'h800); tick();
    chk("ch4_interrupted", health[4], 1'b1);
    send(5'd4, 12'h800);
    chk("ch4_lat1", health[4], 1'b1);
    tick();
    chk("ch4_drop", health[4], 1'b0);
    chk("unsafe_lat2", unsafe, 1'b0);
    tick();
    chk("unsafe_lat3", unsafe, 1'b1);
    tick();
    chk("unsafe_one_cycle", unsafe, 1'b0);
    repeat (3) tick();
    chk("unsafe_count", unsafe_cnt, 1);

    // Unmasked ch5 fault, back-to-back samples.
    wb_acc(1'b1, 16'd37, 16'h0100, r);
    repeat (3) send(5'd5, 12'h800);
    repeat (3) tick();
    chk("ch5_bad", health[5], 1'b0);
    chk("ch5_no_pulse", unsafe_cnt, 1);

    // Disable forces healthy; re-enable must re-earn RECOVER_COUNT samples.
    wb_acc(1'b1, 16'd68, 16'hFFDF, r);
    chk("ch5_disabled", health[5], 1'b1);
    send(5'd5, 12'h800); repeat (3) tick();
    chk("ch5_dis_ignore", health[5], 1'b1);
    wb_acc(1'b1, 16'd68, 16'hFFFF, r);
    chk("ch5_reenabled", health[5], 1'b0);
    send(5'd5, 12'h050);
    send(5'd5, 12'h050);
    tick();
    chk("ch5_two_good", health[5], 1'b0);
    send(5'd5, 12'h050);
    tick();
    chk("ch5_recovered", health[5], 1'b1);
    chk("disable_no_pulse", unsafe_cnt, 1);

    // Inverted window on ch7: every sample is out of range.
    wb_acc(1'b1, 16'd7, 16'h0900, r);
    wb_acc(1'b1, 16'd39, 16'h0100, r);
    send(5'd7, 12'h000);
    send(5'd7, 12'hFFF);
    tick();
    chk("ch7_two", health[7], 1'b1);
    send(5'd7, 12'h950);
    tick();
    chk("ch7_bad", health[7], 1'b0);

    for (int i = 0; i < 16; i++) begin
      wb_acc(vecs[i].we, vecs[i].adr, vecs[i].dat, r);
      if (!vecs[i].we) chk($sformatf("reg_rd[%0d] adr %0d", i, vecs[i].adr), r, vecs[i].exp);
    end
    chk("ack_total", ack_cnt, accesses);

    // Reset mid-operation returns everything to defaults.
    send(5'd0, 12'hFFF);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst2_health", health, 32'h0);
    chk("rst2_unsafe", unsafe, 1'b0);
    wb_acc(1'b0, 16'd32, 16'h0, r);
    chk("rst2_max0", r, 16'h0FFF);
    wb_acc(1'b0, 16'd66, 16'h0, r);
    chk("rst2_mask", r, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
